// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// ex_muldiv : multi-cycle RV32M multiply/divide unit for the execute stage
// Rev 1.0   : initial release
// ============================================================================
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] reg1,
  input  logic [31:0] reg2,
  input  logic [4:0]  wd,
  input  logic        flush,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] result,
  output logic [4:0]  wd_o,
  output logic        wreg_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic [5:0] c_LAST_ITER = 6'd31;

  state_t      state_q;
  logic [1:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  wd_q;
  logic [31:0] dvd_q;
  logic [31:0] dsr_q;
  logic [31:0] rem_q;
  logic [5:0]  cnt_q;
  logic        qneg_q;
  logic        rneg_q;
  logic [31:0] result_q;
  logic [4:0]  wd_out_q;
  logic        done_q;

  logic        w_div_signed;
  logic        w_div_zero;
  logic        w_div_ovf;
  logic        w_special;
  logic [31:0] w_special_res;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;

  // Divide decode is done on the live inputs so special cases skip iteration
  assign w_div_signed = ~op[0];
  assign w_div_zero   = (reg2 == 32'd0);
  assign w_div_ovf    = w_div_signed & (reg1 == 32'h8000_0000) & (reg2 == 32'hFFFF_FFFF);
  assign w_special    = w_div_zero | w_div_ovf;
  assign w_mag1       = (w_div_signed & reg1[31]) ? (~reg1 + 32'd1) : reg1;
  assign w_mag2       = (w_div_signed & reg2[31]) ? (~reg2 + 32'd1) : reg2;

  always_comb begin
    w_special_res = 32'd0;
    if (w_div_zero) begin
      w_special_res = op[1] ? reg1 : 32'hFFFF_FFFF;
    end else begin
      w_special_res = op[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Sign-extended 64-bit operands; the low 64 bits of the product are exact
  logic [63:0] w_a64;
  logic [63:0] w_b64;
  logic [63:0] w_prod;
  logic [31:0] w_mul_res;

  assign w_a64     = {{32{a_q[31] & (op_q != 2'b11)}}, a_q};
  assign w_b64     = {{32{b_q[31] & ~op_q[1]}}, b_q};
  assign w_prod    = w_a64 * w_b64;
  assign w_mul_res = (op_q == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  logic [32:0] w_trial;
  logic        w_qbit;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic [31:0] w_div_res;

  // Restoring step: a borrow out of bit 32 means the trial subtract failed
  assign w_trial   = {rem_q, dvd_q[31]} - {1'b0, dsr_q};
  assign w_qbit    = ~w_trial[32];
  assign w_rem_nx  = w_qbit ? w_trial[31:0] : {rem_q[30:0], dvd_q[31]};
  assign w_quo_nx  = {dvd_q[30:0], w_qbit};
  assign w_div_res = op_q[1] ? (rneg_q ? (~w_rem_nx + 32'd1) : w_rem_nx)
                             : (qneg_q ? (~w_quo_nx + 32'd1) : w_quo_nx);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      op_q     <= 2'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      wd_q     <= 5'd0;
      dvd_q    <= 32'd0;
      dsr_q    <= 32'd0;
      rem_q    <= 32'd0;
      cnt_q    <= 6'd0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
      wd_out_q <= 5'd0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            op_q   <= op[1:0];
            a_q    <= reg1;
            b_q    <= reg2;
            wd_q   <= wd;
            dvd_q  <= w_mag1;
            dsr_q  <= w_mag2;
            rem_q  <= 32'd0;
            cnt_q  <= 6'd0;
            qneg_q <= w_div_signed & (reg1[31] ^ reg2[31]);
            rneg_q <= w_div_signed & reg1[31];
            if (!op[2]) begin
              state_q <= S_MUL;
            end else if (w_special) begin
              result_q <= w_special_res;
              wd_out_q <= wd;
              done_q   <= 1'b1;
              state_q  <= S_FIN;
            end else begin
              state_q <= S_DIV;
            end
          end
        end
        S_MUL: begin
          if (flush) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= w_mul_res;
            wd_out_q <= wd_q;
            done_q   <= 1'b1;
            state_q  <= S_FIN;
          end
        end
        S_DIV: begin
          if (flush) begin
            cnt_q   <= 6'd0;
            state_q <= S_IDLE;
          end else begin
            dvd_q <= w_quo_nx;
            rem_q <= w_rem_nx;
            if (cnt_q == c_LAST_ITER) begin
              cnt_q    <= 6'd0;
              result_q <= w_div_res;
              wd_out_q <= wd_q;
              done_q   <= 1'b1;
              state_q  <= S_FIN;
            end else begin
              cnt_q <= cnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign stall_req = rst & ~flush &
                     (((state_q == S_IDLE) & start) | (state_q == S_MUL) | (state_q == S_DIV));
  assign done      = done_q;
  assign wreg_o    = done_q;
  assign result    = result_q;
  assign wd_o      = wd_out_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// tb_ex_muldiv : scoreboard bench for ex_muldiv (directed RV32M vectors)
// Rev 1.0      : initial release
// ============================================================================
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] reg1;
  logic [31:0] reg2;
  logic [4:0]  wd;
  logic        flush;
  logic        stall_req;
  logic        done;
  logic [31:0] result;
  logic [4:0]  wd_o;
  logic        wreg_o;

  ex_muldiv dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .reg1      (reg1),
    .reg2      (reg2),
    .wd        (wd),
    .flush     (flush),
    .stall_req (stall_req),
    .done      (done),
    .result    (result),
    .wd_o      (wd_o),
    .wreg_o    (wreg_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  wd;
    logic [31:0] at;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (done !== 1'b0) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'd0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("wd_o", {27'd0, wd_o}, {27'd0, e.wd});
        chk("wreg_o", {31'd0, wreg_o}, 32'd1);
        chk("done_cycle", 32'(cyc), e.at);
      end
    end
  end

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] w, input logic [31:0] want,
                     input int lat);
    int T;
    int stalls;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; reg1 = a; reg2 = b; wd = w; flush = 1'b0;
    T = cyc;
    sb.push_back(exp_t'{res: want, wd: w, at: 32'(T + lat)});
    #1;
    stalls = stall_req ? 1 : 0;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      #1;
      if (stall_req) stalls++;
      if (done) seen = 1'b1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(lat));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  wd;
    logic [31:0] want;
    int          lat;
  } vec_t;

  vec_t vecs[18] = '{
    '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 2},
    '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 2},
    '{3'b010, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'hC000_0000, 2},
    '{3'b011, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000, 2},
    '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  32'hFFFF_FFFE, 2},
    '{3'b100, 32'hFFFF_FFF9, 32'd2,          5'd10, 32'hFFFF_FFFD, 33},
    '{3'b110, 32'hFFFF_FFF9, 32'd2,          5'd11, 32'hFFFF_FFFF, 33},
    '{3'b101, 32'd100,        32'd7,          5'd12, 32'd14,        33},
    '{3'b111, 32'd100,        32'd7,          5'd13, 32'd2,         33},
    '{3'b100, 32'd20,         32'hFFFF_FFFD, 5'd14, 32'hFFFF_FFFA, 33},
    '{3'b110, 32'd20,         32'hFFFF_FFFD, 5'd15, 32'd2,         33},
    '{3'b101, 32'd5,          32'd0,          5'd16, 32'hFFFF_FFFF, 1},
    '{3'b110, 32'd5,          32'd0,          5'd17, 32'd5,         1},
    '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1},
    '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'd0,         1},
    '{3'b101, 32'hFFFF_FFFF, 32'd1,          5'd20, 32'hFFFF_FFFF, 33},
    '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd1,  32'd0,         33},
    '{3'b000, 32'h1234_5678, 32'h10,         5'd31, 32'h2345_6780, 2}
  };

  initial begin
    int T;
    rst = 1'b0; start = 1'b0; op = 3'd0; reg1 = 32'd0; reg2 = 32'd0; wd = 5'd0; flush = 1'b0;

    // Reset state, with a start request that must not raise stall_req
    repeat (2) @(negedge clk);
    start = 1'b1; op = 3'b100; reg1 = 32'd9; reg2 = 32'd2; wd = 5'd4;
    #1;
    chk("rst_stall_req", {31'd0, stall_req}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_wd_o", {27'd0, wd_o}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wreg_o", {31'd0, wreg_o}, 32'd0);
    @(negedge clk);
    start = 1'b0; rst = 1'b1;

    foreach (vecs[i])
      run($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wd,
          vecs[i].want, vecs[i].lat);

    // Flush a divide at T+10; a multiply issued at T+11 must finish at T+13
    @(negedge clk);
    start = 1'b1; op = 3'b100; reg1 = 32'd1000; reg2 = 32'd3; wd = 5'd3;
    T = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc != T + 10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_stall_req", {31'd0, stall_req}, 32'd0);
    run("after_flush_mul", 3'b000, 32'd6, 32'd7, 5'd22, 32'd42, 2);

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; op = 3'b100; reg1 = 32'd5000; reg2 = 32'd7; wd = 5'd9;
    T = cyc;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc != T + 5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_wd_o", {27'd0, wd_o}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_wreg_o", {31'd0, wreg_o}, 32'd0);
    chk("midrst_stall_req", {31'd0, stall_req}, 32'd0);
    start = 1'b0;
    rst = 1'b1;
    run("after_rst_mul", 3'b000, 32'd3, 32'd4, 5'd2, 32'd12, 2);

    // Result and wd_o hold after FIN while done drops
    @(negedge clk);
    #1;
    chk("hold_result", result, 32'd12);
    chk("hold_wd_o", {27'd0, wd_o}, 32'd2);
    chk("hold_done", {31'd0, done}, 32'd0);
    chk("hold_stall_req", {31'd0, stall_req}, 32'd0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
